// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin decoder arbiter,
// including the rotating-priority winner search used by the top level.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set request scanning upward from ptr with wrap 3->0.
    // When no request is set the result is ptr; callers gate on |req.
    function automatic logic [ADDR_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [ADDR_W-1:0]  ptr
    );
        logic [ADDR_W-1:0] idx;
        logic [ADDR_W-1:0] pick;
        logic              found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + ADDR_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/grant_decoder.sv
// 2-to-4 decoder with enable; turns the registered winner address into a
// one-hot grant, all outputs low while enable is low.
module grant_decoder (
    input  logic addr0,
    input  logic addr1,
    input  logic enable,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3
);

    assign out0 = enable & ~addr1 & ~addr0;
    assign out1 = enable & ~addr1 &  addr0;
    assign out2 = enable &  addr1 & ~addr0;
    assign out3 = enable &  addr1 &  addr0;

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Four-way round-robin arbiter: registers winner address + enable, decodes them
// into a one-hot grant. Optional grant timeout is compiled in with ARB_TIMEOUT_EN.
module rr_decoder_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               addr0,
    output logic               addr1,
    output logic               enable,
    output logic               timeout
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range
        $error("rr_decoder_arbiter: HOLD_MAX must be within 2..255");
    end

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_enable;
    logic [ADDR_W-1:0] r_ptr;

    arb_state_t        w_next_state;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_next_enable;
    logic [ADDR_W-1:0] w_next_ptr;
    logic [ADDR_W-1:0] w_pick;
    logic              w_release;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold_cnt;
    logic       r_timeout;
    logic [7:0] w_next_hold_cnt;
    logic       w_next_timeout;
    logic       w_force;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_enable <= 1'b0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_addr   <= w_next_addr;
            r_enable <= w_next_enable;
            r_ptr    <= w_next_ptr;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_next_hold_cnt;
            r_timeout  <= w_next_timeout;
        end
    end
`endif

    always_comb begin
        w_next_state  = r_state;
        w_next_addr   = r_addr;
        w_next_enable = r_enable;
        w_next_ptr    = r_ptr;
        w_pick        = rr_pick(req, r_ptr);
        w_release     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_next_hold_cnt = r_hold_cnt;
        w_next_timeout  = 1'b0;
        w_force         = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_next_enable = 1'b0;
                if (|req) begin
                    w_next_addr   = w_pick;
                    w_next_enable = 1'b1;
                    w_next_state  = GRANT;
`ifdef ARB_TIMEOUT_EN
                    w_next_hold_cnt = '0;
`endif
                end
            end
            GRANT: begin
                // done and a dropped request on the same edge are one release.
                w_release = done | ~req[r_addr];
`ifdef ARB_TIMEOUT_EN
                // Count reaches HOLD_MAX-1 on the last allowed grant cycle.
                w_force         = ~w_release & (r_hold_cnt == 8'(HOLD_MAX - 1));
                w_next_hold_cnt = r_hold_cnt + 8'd1;
                w_next_timeout  = w_force;
                if (w_force) begin
                    w_next_enable = 1'b0;
                    w_next_ptr    = r_addr + 2'd1;
                    w_next_state  = IDLE;
                end
`endif
                if (w_release) begin
                    w_next_enable = 1'b0;
                    w_next_ptr    = r_addr + 2'd1;
                    w_next_state  = IDLE;
                end
            end
            default: begin
                w_next_state  = IDLE;
                w_next_enable = 1'b0;
            end
        endcase
    end

    grant_decoder u_grant_decoder (
        .addr0  (r_addr[0]),
        .addr1  (r_addr[1]),
        .enable (r_enable),
        .out0   (gnt[0]),
        .out1   (gnt[1]),
        .out2   (gnt[2]),
        .out3   (gnt[3])
    );

    assign addr0  = r_addr[0];
    assign addr1  = r_addr[1];
    assign enable = r_enable;

`ifdef ARB_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench for rr_decoder_arbiter: directed request/done sequences push
// expected winners; a negedge monitor pops them as each new grant appears.
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic       addr0;
    logic       addr1;
    logic       enable;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_q[$];
    logic [3:0] prev_gnt = 4'b0000;

    rr_decoder_arbiter #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .addr0   (addr0),
        .addr1   (addr1),
        .enable  (enable),
        .timeout (timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [3:0] exp_gnt;
        logic [1:0] e;
        exp_gnt = 4'b0000;
        if (enable === 1'b1) exp_gnt[{addr1, addr0}] = 1'b1;
        chk("decode_consistency", {28'd0, gnt}, {28'd0, exp_gnt});
`ifndef ARB_TIMEOUT_EN
        chk("timeout_tied_low", {31'd0, timeout}, 32'd0);
`endif
        if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", {28'd0, gnt}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                exp_gnt = 4'b0000;
                exp_gnt[e] = 1'b1;
                chk("grant_order", {28'd0, gnt}, {28'd0, exp_gnt});
            end
        end else if (gnt != 4'b0000 && gnt != prev_gnt) begin
            chk("grant_switch_without_idle", {28'd0, gnt}, {28'd0, prev_gnt});
        end
        prev_gnt = gnt;
    end

    // driver tasks
    task automatic wait_grant();
        for (int i = 0; i < 20; i++) begin
            if (gnt != 4'b0000) return;
            @(negedge clk);
        end
        chk("grant_wait_expired", {28'd0, gnt}, 32'd1);
    endtask

    // Hold the current grant for len cycles, then release via done and/or req change.
    task automatic run_grant(input int len, input logic use_done, input logic [3:0] req_after);
        wait_grant();
        for (int i = 1; i < len; i++) @(negedge clk);
        done = use_done;
        req  = req_after;
        @(negedge clk);
        done = 1'b0;
        chk("idle_after_release", {28'd0, gnt}, 32'd0);
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        chk("reset_gnt", {28'd0, gnt}, 32'd0);
        chk("reset_enable", {31'd0, enable}, 32'd0);
        chk("reset_addr", {30'd0, addr1, addr0}, 32'd0);
        chk("reset_timeout", {31'd0, timeout}, 32'd0);
        reset = 1'b0;

        // no requests: stay idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_no_req_enable", {31'd0, enable}, 32'd0);
            chk("idle_no_req_timeout", {31'd0, timeout}, 32'd0);
        end

        // all requesting: 0,1,2,3,0
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) run_grant(2, 1'b1, 4'b1111);
        run_grant(2, 1'b1, 4'b0000);

        // serve 1 (done + req drop together), then wrap from ptr=2 to 0, then 1
        exp_q.push_back(2'd1);
        req = 4'b0010;
        run_grant(2, 1'b1, 4'b0000);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        req = 4'b0011;
        run_grant(2, 1'b1, 4'b0011);
        run_grant(2, 1'b1, 4'b0000);

        // requester 2 drops its request while 0 keeps asking
        exp_q.push_back(2'd2); exp_q.push_back(2'd0);
        req = 4'b0101;
        run_grant(2, 1'b0, 4'b0001);
        @(negedge clk);
        chk("wrap_after_drop", {28'd0, gnt}, 32'h1);
        run_grant(2, 1'b1, 4'b0000);

        // requester 1 holds without done
        exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        req = 4'b0110;
        wait_grant();
`ifdef ARB_TIMEOUT_EN
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != 4'b0010) break;
            cnt++;
        end
        chk("timeout_grant_len", cnt, 32'd4);
        chk("timeout_idle_gnt", {28'd0, gnt}, 32'd0);
        chk("timeout_pulse", {31'd0, timeout}, 32'd1);
        @(negedge clk);
        chk("timeout_pulse_end", {31'd0, timeout}, 32'd0);
        run_grant(2, 1'b1, 4'b0000);
`else
        cnt = 1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (gnt == 4'b0010) cnt++;
        end
        chk("long_grant_held", cnt, 32'd20);
        done = 1'b1;
        req  = 4'b0100;
        @(negedge clk);
        done = 1'b0;
        chk("long_grant_release", {28'd0, gnt}, 32'd0);
        run_grant(2, 1'b1, 4'b0000);
`endif

        // reset in the middle of requester 3's grant
        exp_q.push_back(2'd3);
        req = 4'b1000;
        wait_grant();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_reset_gnt", {28'd0, gnt}, 32'd0);
        chk("async_reset_enable", {31'd0, enable}, 32'd0);
        chk("async_reset_addr", {30'd0, addr1, addr0}, 32'd0);
        chk("async_reset_timeout", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(2'd0);
        req = 4'b1001;
        run_grant(2, 1'b1, 4'b0000);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
